// File: rtl/falco_pkg.sv
// Falco shared types: the AGU->LSU payload and the AGU->LSU queue depth.
package Falco_pkg;

  localparam int AGU_LSU_Q_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        is_store;
    logic [3:0]  rob_id;
  } agu_pack_t;

  // One queue slot: payload plus its memory-align exception flag.
  typedef struct packed {
    agu_pack_t pack;
    logic      misalign;
  } agu_lsu_entry_t;

endpackage

// File: rtl/agu_lsu_queue.sv
// AGU->LSU instruction queue that stops accepting behind a misaligned entry.
// Optional AGU_LSU_QUEUE_BYPASS_EN: zero-latency pass-through while the queue is empty.
module agu_lsu_queue
  import Falco_pkg::*;
#(
  parameter int DEPTH = AGU_LSU_Q_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  agu_pack_t        in_pack,
  input  logic             in_misalign,
  output logic             in_ready,
  output logic             out_valid,
  output agu_pack_t        out_pack,
  output logic             out_misalign,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

  agu_lsu_entry_t   mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             block_r;

  agu_lsu_entry_t   head_s;
  logic             empty_s;
  logic             full_s;
  logic             bypass_s;
  logic             push_s;
  logic             pop_s;
  logic             write_s;
  logic             read_s;

  assign head_s = mem_r[rd_ptr_r];
  assign count  = count_r;

  // Handshakes, output selection and which events touch storage.
  always_comb begin
    empty_s  = (count_r == CNT_ZERO);
    full_s   = (count_r == CNT_FULL);
    in_ready = !flush && !block_r && !full_s;
`ifdef AGU_LSU_QUEUE_BYPASS_EN
    bypass_s = empty_s;
`else
    bypass_s = 1'b0;
`endif
    if (bypass_s) begin
      out_valid    = in_valid && !flush;
      out_pack     = in_pack;
      out_misalign = in_misalign;
    end else begin
      out_valid    = !flush && !empty_s;
      out_pack     = head_s.pack;
      out_misalign = head_s.misalign;
    end
    push_s  = in_valid && in_ready;
    pop_s   = out_valid && out_ready;
    // A bypassed entry taken in the same cycle never lands in storage.
    write_s = push_s && !(bypass_s && pop_s);
    read_s  = pop_s && !bypass_s;
  end

  // Pointers, occupancy and exception block; rst outranks flush, flush outranks traffic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      block_r  <= 1'b0;
    end else begin
      if (write_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (read_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({write_s, read_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      // Setting wins so a pop alongside a misaligned push leaves the queue blocked.
      if (write_s && in_misalign) begin
        block_r <= 1'b1;
      end else if (read_s && head_s.misalign) begin
        block_r <= 1'b0;
      end else begin
        block_r <= block_r;
      end
    end
  end

  // Entry storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem_r[wr_ptr_r] <= {in_pack, in_misalign};
    end
  end

endmodule

// File: tb/tb_agu_lsu_queue.sv
// Directed bench for agu_lsu_queue: stimulus pushes expected entries, a monitor checks pops.
module tb_agu_lsu_queue;
  import Falco_pkg::*;

  localparam int CNT_W = $clog2(AGU_LSU_Q_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  agu_pack_t        in_pack = '0;
  logic             in_misalign = 1'b0;
  logic             in_ready;
  logic             out_valid;
  agu_pack_t        out_pack;
  logic             out_misalign;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] count;

  int n_vec = 0;
  int n_mis = 0;
  agu_lsu_entry_t exp_q[$];
  agu_lsu_entry_t mon_e;

  agu_lsu_queue #(.DEPTH(AGU_LSU_Q_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pack(in_pack), .in_misalign(in_misalign), .in_ready(in_ready),
    .out_valid(out_valid), .out_pack(out_pack), .out_misalign(out_misalign),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  function automatic agu_pack_t mkpack(input logic [31:0] pc);
    agu_pack_t p;
    p.pc       = pc;
    p.addr     = pc + 32'h8000_0000;
    p.size     = pc[3:2];
    p.is_store = pc[2];
    p.rob_id   = pc[5:2];
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // One cycle: drive just after the rising edge, return at the falling edge.
  task automatic step(input logic r, input logic v, input logic [31:0] pc, input logic mis,
                      input logic ordy, input logic fl, input logic acc);
    agu_lsu_entry_t e;
    @(posedge clk);
    #1;
    rst = r; flush = fl; in_valid = v; in_misalign = mis; out_ready = ordy;
    in_pack = mkpack(pc);
    if (r || fl) exp_q.delete();
    if (acc) begin
      e.pack = in_pack;
      e.misalign = mis;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every consumed head must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL pop_unexpected: got pc %h, expected no pop", out_pack.pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_pack !== mon_e.pack || out_misalign !== mon_e.misalign) begin
          n_mis++;
          $display("FAIL pop_entry: got pc %h pack %h mis %b, expected pc %h pack %h mis %b",
                   out_pack.pc, out_pack, out_misalign, mon_e.pack.pc, mon_e.pack, mon_e.misalign);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Fill to DEPTH without consuming, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h100 + i * 32'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Push and pop together at full: only the pop happens.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h100 + i * 32'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h1F0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("full_pp_in_ready", 32'(in_ready), 32'd0);
    idle();
    chk("full_pp_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("full_pp_drain", 32'(count), 32'd0);

    // Push into an empty queue with the LSU ready.
    step(1'b0, 1'b1, 32'h140, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef AGU_LSU_QUEUE_BYPASS_EN
    chk("empty_push_out_valid", 32'(out_valid), 32'd1);
    chk("empty_push_pc", out_pack.pc, 32'h140);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("empty_next_out_valid", 32'(out_valid), 32'd0);
`else
    chk("empty_push_out_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("empty_next_out_valid", 32'(out_valid), 32'd1);
    chk("empty_next_pc", out_pack.pc, 32'h140);
`endif
    idle();
    chk("empty_after_count", 32'(count), 32'd0);

    // Misaligned entry blocks younger pushes until it leaves.
    step(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("block_count", 32'(count), 32'd1);
    chk("block_in_ready", 32'(in_ready), 32'd0);
    chk("block_out_misalign", 32'(out_misalign), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("unblock_in_ready", 32'(in_ready), 32'd1);
    chk("unblock_count", 32'(count), 32'd0);

    // Flush with traffic at count = 3.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h400 + i * 32'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("pre_flush_count", 32'(count), 32'd3);
    step(1'b0, 1'b1, 32'h4F0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    idle();
    chk("post_flush_count", 32'(count), 32'd0);
    chk("post_flush_out_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("post_flush_drain", 32'(count), 32'd0);

    // Ten push/pop iterations wrap the pointers twice.
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 10; i++) begin
      step(1'b0, 1'b1, i * 32'd4, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("wrap_count", 32'(count), 32'd1);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("wrap_end_count", 32'(count), 32'd0);

    // Reset mid-stream with two entries held.
    step(1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h604, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h6F0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd2);
    idle();
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);

`ifdef AGU_LSU_QUEUE_BYPASS_EN
    step(1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("bypass_out_valid", 32'(out_valid), 32'd1);
    chk("bypass_pc", out_pack.pc, 32'h300);
    step(1'b0, 1'b1, 32'h340, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("bypass_count", 32'(count), 32'd0);
    idle();
    chk("bypass_mis_count", 32'(count), 32'd0);
    chk("bypass_mis_in_ready", 32'(in_ready), 32'd1);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
